dram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port DRAM between core0 and core1 in the dual-core build. It accepts each core's data-memory request (Mem_Ctrl, DAddress, Ddout), grants the DRAM to one core at a time with round-robin priority, sequences the synchronous-read latency, and returns read data and a one-cycle dacq completion pulse to the owning core. It sits between the cores' data ports and the DRAM instance.

---
 rtl/dram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dram_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter
// Shares one single-port synchronous DRAM between two cores. Each core posts a
// request on Mem_Ctrl (bit 0 read, bit 1 write; a write wins if both are set) and
// holds it until its dacq pulse. Grants rotate between the cores: on a tie the
// core that did not own the previous access goes first. Every access runs
// IDLE -> ACCESS -> (RDATA for reads) -> DONE. Because the FSM passes through
// IDLE between accesses, one access always finishes before the next grant.
//
// Ports
//   CLK, rst_n                   clock, asynchronous active-low reset
//   Mem_Ctrl0/1                  per-core request control
//   DAddress0/1                  per-core address
//   Ddout0/1                     per-core write data
//   Ddin0/1                      per-core read data (registered, held until the next read)
//   dacq0/1                      per-core one-cycle completion pulse
//   dram_addr/dram_data/dram_wren  DRAM command, registered, zero when not accessing
//   dram_q                       DRAM read data, valid the cycle after the address is sampled
//   busy                         access in flight or any request pending
//   acc_cnt0/1                   completed-access counters, wrap at 16 bits
module dram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic [3:0]    Mem_Ctrl0,
    input  logic [3:0]    Mem_Ctrl1,
    input  logic [AW-1:0] DAddress0,
    input  logic [AW-1:0] DAddress1,
    input  logic [DW-1:0] Ddout0,
    input  logic [DW-1:0] Ddout1,
    output logic [DW-1:0] Ddin0,
    output logic [DW-1:0] Ddin1,
    output logic          dacq0,
    output logic          dacq1,
    output logic [AW-1:0] dram_addr,
    output logic [DW-1:0] dram_data,
    output logic          dram_wren,
    input  logic [DW-1:0] dram_q,
    output logic          busy,
    output logic [15:0]   acc_cnt0,
    output logic [15:0]   acc_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_r;
    logic          owner_r;
    logic          prio_r;
    logic          is_wr_r;
    logic [DW-1:0] ddin0_r;
    logic [DW-1:0] ddin1_r;
    logic          dacq0_r;
    logic          dacq1_r;
    logic [AW-1:0] dram_addr_r;
    logic [DW-1:0] dram_data_r;
    logic          dram_wren_r;
    logic [15:0]   acc_cnt0_r;
    logic [15:0]   acc_cnt1_r;

    logic          req0_s;
    logic          req1_s;
    logic          grant_owner_s;
    logic [3:0]    grant_ctrl_s;
    logic [AW-1:0] grant_addr_s;
    logic [DW-1:0] grant_data_s;
    logic          busy_s;

    // Request decode and choice of the core that would be granted from IDLE.
    always_comb begin
        req0_s = Mem_Ctrl0[0] | Mem_Ctrl0[1];
        req1_s = Mem_Ctrl1[0] | Mem_Ctrl1[1];
        if (req0_s && req1_s) begin
            grant_owner_s = prio_r;
        end else if (req1_s) begin
            grant_owner_s = 1'b1;
        end else begin
            grant_owner_s = 1'b0;
        end
        if (grant_owner_s) begin
            grant_ctrl_s = Mem_Ctrl1;
            grant_addr_s = DAddress1;
            grant_data_s = Ddout1;
        end else begin
            grant_ctrl_s = Mem_Ctrl0;
            grant_addr_s = DAddress0;
            grant_data_s = Ddout0;
        end
        busy_s = (state_r != ST_IDLE) | req0_s | req1_s;
    end

    // Access sequencer: state, ownership, DRAM command and per-core results.
    // The DRAM command is loaded on entry to ACCESS so that it is valid for the
    // whole ACCESS cycle (and RDATA for reads), and cleared on entry to DONE.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            prio_r      <= 1'b0;
            is_wr_r     <= 1'b0;
            ddin0_r     <= '0;
            ddin1_r     <= '0;
            dacq0_r     <= 1'b0;
            dacq1_r     <= 1'b0;
            dram_addr_r <= '0;
            dram_data_r <= '0;
            dram_wren_r <= 1'b0;
            acc_cnt0_r  <= 16'd0;
            acc_cnt1_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req0_s || req1_s) begin
                        owner_r     <= grant_owner_s;
                        is_wr_r     <= grant_ctrl_s[1];
                        dram_addr_r <= grant_addr_s;
                        dram_data_r <= grant_data_s;
                        dram_wren_r <= grant_ctrl_s[1];
                        state_r     <= ST_ACCESS;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    dram_wren_r <= 1'b0;
                    if (is_wr_r) begin
                        dram_addr_r <= '0;
                        dram_data_r <= '0;
                        dacq0_r     <= ~owner_r;
                        dacq1_r     <= owner_r;
                        state_r     <= ST_DONE;
                    end else begin
                        // Keep the address up while the DRAM returns data.
                        state_r     <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (owner_r) begin
                        ddin1_r <= dram_q;
                    end else begin
                        ddin0_r <= dram_q;
                    end
                    dram_addr_r <= '0;
                    dram_data_r <= '0;
                    dacq0_r     <= ~owner_r;
                    dacq1_r     <= owner_r;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    dacq0_r <= 1'b0;
                    dacq1_r <= 1'b0;
                    if (owner_r) begin
                        acc_cnt1_r <= acc_cnt1_r + 16'd1;
                    end else begin
                        acc_cnt0_r <= acc_cnt0_r + 16'd1;
                    end
                    // The core just served yields the next tie.
                    prio_r  <= ~owner_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    dacq0_r     <= 1'b0;
                    dacq1_r     <= 1'b0;
                    dram_addr_r <= '0;
                    dram_data_r <= '0;
                    dram_wren_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ddin0     = ddin0_r;
    assign Ddin1     = ddin1_r;
    assign dacq0     = dacq0_r;
    assign dacq1     = dacq1_r;
    assign dram_addr = dram_addr_r;
    assign dram_data = dram_data_r;
    assign dram_wren = dram_wren_r;
    assign busy      = busy_s;
    assign acc_cnt0  = acc_cnt0_r;
    assign acc_cnt1  = acc_cnt1_r;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
// Directed bench for dram_arbiter. It holds a DRAM model and a transaction-level
// reference model. The reference model counts cycles since each grant. A
// compare process checks every DUT output against the model on each falling
// edge. Hand-computed literals pin the model: latencies, read data, counters.
module tb_dram_arbiter;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [3:0]  Mem_Ctrl0, Mem_Ctrl1;
    logic [7:0]  DAddress0, DAddress1, Ddout0, Ddout1;
    logic [7:0]  Ddin0, Ddin1;
    logic        dacq0, dacq1;
    logic [7:0]  dram_addr, dram_data, dram_q;
    logic        dram_wren, busy;
    logic [15:0] acc_cnt0, acc_cnt1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    always #5 CLK = ~CLK;

    dram_arbiter #(.AW(8), .DW(8)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .Mem_Ctrl0(Mem_Ctrl0), .Mem_Ctrl1(Mem_Ctrl1),
        .DAddress0(DAddress0), .DAddress1(DAddress1),
        .Ddout0(Ddout0), .Ddout1(Ddout1),
        .Ddin0(Ddin0), .Ddin1(Ddin1),
        .dacq0(dacq0), .dacq1(dacq1),
        .dram_addr(dram_addr), .dram_data(dram_data), .dram_wren(dram_wren),
        .dram_q(dram_q), .busy(busy),
        .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
    );

    // Synchronous single-port DRAM, preloaded.
    logic [7:0] ram [256] = '{8'h20: 8'h11, 8'h30: 8'h22, default: 8'h00};
    always @(posedge CLK) begin
        if (dram_wren) ram[dram_addr] <= dram_data;
        dram_q <= ram[dram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. k counts the cycles since the grant edge: 0 means no
    // access. dacq appears at k == latency, which is 2 for a write and 3 for a
    // read. The following edge retires the access.
    int          k = 0;
    bit          m_owner = 1'b0, m_prio = 1'b0, m_wr = 1'b0;
    logic [7:0]  m_addr = 8'h00, m_data = 8'h00;
    logic [7:0]  m_ddin [2] = '{8'h00, 8'h00};
    logic [15:0] m_cnt [2] = '{16'd0, 16'd0};
    logic [7:0]  shadow [256] = '{8'h20: 8'h11, 8'h30: 8'h22, default: 8'h00};

    wire m_req0 = Mem_Ctrl0[0] | Mem_Ctrl0[1];
    wire m_req1 = Mem_Ctrl1[0] | Mem_Ctrl1[1];

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            k         <= 0;
            m_owner   <= 1'b0;
            m_prio    <= 1'b0;
            m_wr      <= 1'b0;
            m_ddin[0] <= 8'h00;
            m_ddin[1] <= 8'h00;
            m_cnt[0]  <= 16'd0;
            m_cnt[1]  <= 16'd0;
        end else if (k == 0) begin
            if (m_req0 || m_req1) begin
                if (m_req0 && m_req1) begin
                    m_owner <= m_prio;
                    m_wr    <= m_prio ? Mem_Ctrl1[1] : Mem_Ctrl0[1];
                    m_addr  <= m_prio ? DAddress1 : DAddress0;
                    m_data  <= m_prio ? Ddout1 : Ddout0;
                end else begin
                    m_owner <= m_req1;
                    m_wr    <= m_req1 ? Mem_Ctrl1[1] : Mem_Ctrl0[1];
                    m_addr  <= m_req1 ? DAddress1 : DAddress0;
                    m_data  <= m_req1 ? Ddout1 : Ddout0;
                end
                k <= 1;
            end
        end else if (k == (m_wr ? 2 : 3)) begin
            m_cnt[m_owner] <= m_cnt[m_owner] + 16'd1;
            m_prio <= !m_owner;
            k <= 0;
        end else begin
            if (k == 1 && m_wr) shadow[m_addr] <= m_data;
            if (k == 2 && !m_wr) m_ddin[m_owner] <= shadow[m_addr];
            k <= k + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        int  lat_v;
        bit  act_v;
        if (check_en) begin
            lat_v = m_wr ? 2 : 3;
            act_v = (k >= 1) && (k < lat_v);
            check("dacq0", dacq0, (k == lat_v) && !m_owner);
            check("dacq1", dacq1, (k == lat_v) && m_owner);
            check("dram_addr", dram_addr, act_v ? m_addr : 8'h00);
            check("dram_data", dram_data, act_v ? m_data : 8'h00);
            check("dram_wren", dram_wren, (k == 1) && m_wr);
            check("busy", busy, (k != 0) || m_req0 || m_req1);
            check("Ddin0", Ddin0, m_ddin[0]);
            check("Ddin1", Ddin1, m_ddin[1]);
            check("acc_cnt0", acc_cnt0, m_cnt[0]);
            check("acc_cnt1", acc_cnt1, m_cnt[1]);
        end
    end

    // Post requests and wait for completion. Each core drops its request after
    // it sees dacq. e0/e1 give the expected dacq cycle counted from the request
    // cycle, or -1 for a core that does not request. A missed bound shows up as
    // a latency mismatch.
    task automatic issue(input logic [3:0] c0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic [3:0] c1, input logic [7:0] a1, input logic [7:0] d1,
                         input int e0, input int e1);
        bit want0, want1, clr0, clr1;
        int t0, t1;
        want0 = (c0[1:0] != 2'b00);
        want1 = (c1[1:0] != 2'b00);
        Mem_Ctrl0 = c0; DAddress0 = a0; Ddout0 = d0;
        Mem_Ctrl1 = c1; DAddress1 = a1; Ddout1 = d1;
        t0 = -1; t1 = -1;
        for (int cyc = 0; cyc < 40 && ((want0 && t0 < 0) || (want1 && t1 < 0)); cyc++) begin
            @(negedge CLK);
            clr0 = 1'b0; clr1 = 1'b0;
            if (want0 && t0 < 0 && dacq0) begin t0 = cyc; clr0 = 1'b1; end
            if (want1 && t1 < 0 && dacq1) begin t1 = cyc; clr1 = 1'b1; end
            @(posedge CLK); #1;
            if (clr0) Mem_Ctrl0 = 4'h0;
            if (clr1) Mem_Ctrl1 = 4'h0;
        end
        if (want0) check("latency0", t0, e0);
        if (want1) check("latency1", t1, e1);
        Mem_Ctrl0 = 4'h0;
        Mem_Ctrl1 = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        Mem_Ctrl0 = 4'h1; DAddress0 = 8'h20; Ddout0 = 8'h00;
        Mem_Ctrl1 = 4'h1; DAddress1 = 8'h30; Ddout1 = 8'h00;
        @(posedge CLK); #1;
        check_en = 1'b1;

        // Reset held with both cores requesting.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_dacq", {dacq0, dacq1}, 2'b00);
        check("rst_wren", dram_wren, 1'b0);
        check("rst_addr", dram_addr, 8'h00);
        rst_n = 1'b1;

        // Contention on reads: core0 first (T+3), then core1 (T+7).
        issue(4'h1, 8'h20, 8'h00, 4'h1, 8'h30, 8'h00, 3, 7);
        check("contend_ddin0", Ddin0, 8'h11);
        check("contend_ddin1", Ddin1, 8'h22);

        // Single write, then read back.
        issue(4'h2, 8'h10, 8'hA5, 4'h0, 8'h00, 8'h00, 2, -1);
        check("wr_cnt0", acc_cnt0, 16'd2);
        issue(4'h1, 8'h10, 8'h00, 4'h0, 8'h00, 8'h00, 3, -1);
        check("rd_ddin0", Ddin0, 8'hA5);
        check("rd_ddin1_held", Ddin1, 8'h22);
        check("rd_cnt0", acc_cnt0, 16'd3);
        check("rd_cnt1", acc_cnt1, 16'd1);

        // Fairness over 10 accesses: core0 writes, core1 reads it back next.
        rst_n = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(4'h2, 8'(8'h40 + i), 8'(8'h50 + i), 4'h1, 8'(8'h40 + i), 8'h00, 2, 6);
            check("fair_ddin1", Ddin1, 8'(8'h50 + i));
        end
        check("fair_cnt0", acc_cnt0, 16'd5);
        check("fair_cnt1", acc_cnt1, 16'd5);

        // Reset in the middle of a read.
        rst_n = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        Mem_Ctrl0 = 4'h1; DAddress0 = 8'h20;
        @(posedge CLK);
        @(posedge CLK); #1;
        check("midrd_addr", dram_addr, 8'h20);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrd_dacq0", dacq0, 1'b0);
        check("midrd_wren", dram_wren, 1'b0);
        check("midrd_addr0", dram_addr, 8'h00);
        check("midrd_ddin0", Ddin0, 8'h00);
        check("midrd_busy", busy, 1'b1);
        Mem_Ctrl0 = 4'h0;
        @(posedge CLK); #1;
        check("midrd_busy_idle", busy, 1'b0);
        check("midrd_ddin0_after", Ddin0, 8'h00);
        rst_n = 1'b1;

        // Both control bits on core1 act as a write.
        issue(4'h0, 8'h00, 8'h00, 4'h3, 8'h05, 8'h3C, -1, 2);
        check("both_ddin1", Ddin1, 8'h00);
        check("both_ram", ram[5], 8'h3C);
        check("both_cnt1", acc_cnt1, 16'd1);

        repeat (2) @(posedge CLK);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
